// File: rtl/tff_seq_ctrl.sv
// Button-driven sequencer producing one-cycle toggle enables for a 3-bit TFF bank.
// Optional debouncer on each synchronised button: define TFF_SEQ_DEBOUNCE_EN.
module tff_seq_ctrl #(
    parameter int DIV_MAX   = 4,
    parameter int DIV_W     = 8,
    parameter int DB_CYCLES = 3
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_dir,
    input  logic [2:0] q,
    output logic [2:0] t,
    output logic       dir,
    output logic       busy,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } state_t;

    generate
        if (DIV_MAX < 2) begin : g_bad_div
            $error("DIV_MAX must be at least 2");
        end
        if (DIV_MAX - 1 >= (2 ** DIV_W)) begin : g_bad_divw
            $error("DIV_W too narrow for DIV_MAX");
        end
        if (DB_CYCLES < 1) begin : g_bad_db
            $error("DB_CYCLES must be at least 1");
        end
    endgenerate

    // Button vector ordering: bit 0 = run, bit 1 = step, bit 2 = dir.
    logic [2:0] btn_raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] level;
    logic [2:0] edge_q;
    logic [2:0] press;

    assign btn_raw = {btn_dir, btn_step, btn_run};

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= btn_raw;
            sync2  <= sync1;
            edge_q <= level;
        end
    end

`ifdef TFF_SEQ_DEBOUNCE_EN
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      db_level;

    // Level follows the synchronised input only after DB_CYCLES consecutive disagreements.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            db_level <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != db_level[i]) begin
                    if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                        db_level[i] <= sync2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign level = db_level;
`else
    assign level = sync2;
`endif

    assign press = level & ~edge_q;

    logic             press_run;
    logic             press_step;
    logic             press_dir;
    state_t           cur;
    state_t           nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             load_t;
    logic [2:0]       pattern;

    assign press_run  = press[0];
    assign press_step = press[1];
    assign press_dir  = press[2];

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) cur <= S_IDLE;
        else       cur <= nxt;
    end

    // Run beats step when both arrive together in IDLE.
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE: begin
                if (press_run)       nxt = S_RUN;
                else if (press_step) nxt = S_STEP;
            end
            S_RUN:   if (press_run) nxt = S_IDLE;
            S_STEP:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (cur == S_RUN);
        tick    = (div_cnt == DIV_W'(DIV_MAX - 1));
        load_t  = ((cur == S_RUN) && tick && !press_run) || (cur == S_STEP);
        pattern = dir ? {~q[0] & ~q[1], ~q[0], 1'b1}
                      : { q[0] &  q[1],  q[0], 1'b1};
    end

    // Pattern uses the current dir, so a same-cycle dir press affects only later pulses.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            t       <= '0;
            dir     <= 1'b0;
        end else begin
            if (cur == S_RUN && !press_run && !tick) div_cnt <= div_cnt + 1'b1;
            else                                     div_cnt <= '0;
            t   <= load_t ? pattern : 3'b000;
            dir <= dir ^ press_dir;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// Directed bench for tff_seq_ctrl: vector table for single steps plus free-run and corner sequences.
module tb_tff_seq_ctrl;

`ifdef TFF_SEQ_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif
    localparam int SETTLE = 8;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       btn_run, btn_step, btn_dir;
    logic [2:0] q_set, q_model, q_in;
    logic       model_en;
    logic [2:0] t;
    logic       dir, busy;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    logic exp_dir;

    typedef struct {
        logic       d;
        logic [2:0] q;
        logic [2:0] t;
    } vec_t;
    vec_t vecs [9];

    assign q_in = model_en ? q_model : q_set;

    tff_seq_ctrl #(.DIV_MAX(4), .DIV_W(8), .DB_CYCLES(3)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .btn_dir  (btn_dir),
        .q        (q_in),
        .t        (t),
        .dir      (dir),
        .busy     (busy),
        .state    (state)
    );

    always #5 sysclk = ~sysclk;

    // Behavioural TFF bank closing the loop during free run.
    always @(posedge sysclk or posedge reset) begin
        if (reset)         q_model <= 3'b000;
        else if (model_en) q_model <= q_model ^ t;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Raise the masked buttons, return just after the edge that acts on the press.
    task automatic press(input logic [2:0] m);
        {btn_dir, btn_step, btn_run} = m;
        repeat (LAT) step();
        {btn_dir, btn_step, btn_run} = 3'b000;
    endtask

    initial begin
        vecs[0] = '{1'b0, 3'b011, 3'b111};
        vecs[1] = '{1'b0, 3'b000, 3'b001};
        vecs[2] = '{1'b0, 3'b101, 3'b011};
        vecs[3] = '{1'b0, 3'b111, 3'b111};
        vecs[4] = '{1'b1, 3'b000, 3'b111};
        vecs[5] = '{1'b1, 3'b110, 3'b011};
        vecs[6] = '{1'b1, 3'b011, 3'b001};
        vecs[7] = '{1'b1, 3'b100, 3'b111};
        vecs[8] = '{1'b1, 3'b101, 3'b001};

        reset = 1'b1;
        {btn_dir, btn_step, btn_run} = 3'b000;
        model_en = 1'b0;
        q_set = 3'b101;
        exp_dir = 1'b0;

        // Reset held and released
        repeat (3) step();
        check("rst_t", t, 0);
        check("rst_dir", dir, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state, 0);
        reset = 1'b0;
        repeat (2) step();
        check("rel_t", t, 0);
        check("rel_state", state, 0);
        check("rel_busy", busy, 0);

        // Single steps from the vector table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].d != exp_dir) begin
                press(3'b100);
                exp_dir = ~exp_dir;
                check("vec_dir", dir, exp_dir);
            end
            q_set = vecs[i].q;
            press(3'b010);
            check("vec_in_step", state, 2);
            check("vec_t_pre", t, 0);
            step();
            check("vec_t", t, vecs[i].t);
            check("vec_back_idle", state, 0);
            step();
            check("vec_t_once", t, 0);
            repeat (SETTLE) step();
        end

        press(3'b100);
        check("dir_restore", dir, 0);
        repeat (SETTLE) step();

        // Free run with the model bank; stop press lands on a tick edge
        model_en = 1'b1;
        press(3'b001);
        check("run_state", state, 1);
        check("run_busy", busy, 1);
        check("run_t0", t, 0);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            int k, npulse;
            logic [2:0] kq, exp_t;
            step();
            npulse = (cyc - 1) / 4;
            if (npulse > 8) npulse = 8;
            k  = (cyc / 4) - 1;
            kq = 3'(k);
            exp_t = ((cyc % 4 == 0) && (cyc < 36)) ? (kq ^ (kq + 3'd1)) : 3'b000;
            check("run_t", t, exp_t);
            check("run_q", q_in, npulse % 8);
            check("run_busy_cyc", busy, (cyc < 36) ? 1 : 0);
            if (cyc == 36 - LAT) btn_run = 1'b1;
            if (cyc == 36)       btn_run = 1'b0;
        end
        check("stop_state", state, 0);
        model_en = 1'b0;
        repeat (SETTLE) step();

        // Run and step together, then a dir press on a tick edge
        q_set = 3'b000;
        press(3'b011);
        check("both_state", state, 1);
        check("both_t", t, 0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            logic [2:0] exp_t;
            step();
            exp_t = (cyc == 12) ? 3'b111 : ((cyc == 4 || cyc == 8) ? 3'b001 : 3'b000);
            check("tick_t", t, exp_t);
            check("tick_state", state, 1);
            check("tick_dir", dir, (cyc >= 8) ? 1 : 0);
            if (cyc == 8 - LAT) btn_dir = 1'b1;
            if (cyc == 8)       btn_dir = 1'b0;
        end

        // Asynchronous reset while a pulse is on t
        #2 reset = 1'b1;
        #1;
        check("arst_t", t, 0);
        check("arst_state", state, 0);
        check("arst_busy", busy, 0);
        check("arst_dir", dir, 0);
        repeat (2) step();
        reset = 1'b0;
        repeat (4) step();
        check("post_rst_t", t, 0);
        check("post_rst_state", state, 0);

`ifdef TFF_SEQ_DEBOUNCE_EN
        // Short glitch must be rejected
        q_set = 3'b001;
        btn_step = 1'b1;
        repeat (2) step();
        btn_step = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            check("glitch_t", t, 0);
            check("glitch_state", state, 0);
        end

        // Five-cycle press gives one step
        btn_step = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 5) btn_step = 1'b0;
            if (c == 6) check("db_step_state", state, 2);
            check("db_t", t, (c == 7) ? 3 : 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
